bin_to_bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using the shift-add-3 (double-dabble) algorithm.
- Sits between the 16-bit counter and the display controller: it takes the binary count and produces packed decimal digits for display_value, so the 7-segment shows decimal instead of hex.
- Start/busy/done handshake; one bit processed per clock; the result is held stable between conversions.

---
 rtl/bin_to_bcd_seq_pkg.sv | 15 +
 rtl/bin_to_bcd_seq_digit_adjust.sv | 16 +
 rtl/bin_to_bcd_seq.sv | 86 ++++++++
 tb/tb_bin_to_bcd_seq.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants and state encoding for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

    localparam int unsigned DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [DIGIT_W-1:0] BCD_ADJ_ADD    = 4'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        FINISH  = 2'd2
    } state_t;

endpackage

// File: rtl/bin_to_bcd_seq_digit_adjust.sv
// One BCD digit pre-shift correction: values 5..9 get +3 so the following shift carries correctly.
module bcd_digit_adjust
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] adjusted
);

    always_comb begin
        adjusted = digit;
        if (digit >= BCD_ADJ_THRESH) begin
            adjusted = digit + BCD_ADJ_ADD;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Double-dabble binary-to-BCD converter, one input bit per clock, with start/busy/done handshake.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int unsigned IN_WIDTH   = 16,
    parameter int unsigned NUM_DIGITS = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [IN_WIDTH-1:0]           bin_in,
    output logic                          busy,
    output logic                          done,
    output logic [DIGIT_W*NUM_DIGITS-1:0] bcd_out,
    output logic                          overflow
);

    localparam int unsigned BCD_W = DIGIT_W * NUM_DIGITS;
    localparam int unsigned CNT_W = $clog2(IN_WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_WIDTH - 1);

    state_t              state;
    logic [IN_WIDTH-1:0] bin_sr;
    logic [BCD_W-1:0]    bcd_sr;
    logic [BCD_W-1:0]    bcd_adj;
    logic [CNT_W-1:0]    cnt;
    logic                ovf_acc;

    // All digits corrected in parallel ahead of the shift.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit    (bcd_sr[i*DIGIT_W +: DIGIT_W]),
            .adjusted (bcd_adj[i*DIGIT_W +: DIGIT_W])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            bin_sr   <= '0;
            bcd_sr   <= '0;
            cnt      <= '0;
            ovf_acc  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr  <= bin_in;
                        bcd_sr  <= '0;
                        cnt     <= '0;
                        ovf_acc <= 1'b0;
                        busy    <= 1'b1;
                        state   <= CONVERT;
                    end
                end
                CONVERT: begin
                    // Bit leaving the top digit means the value needs more digits than we have.
                    bcd_sr  <= {bcd_adj[BCD_W-2:0], bin_sr[IN_WIDTH-1]};
                    bin_sr  <= {bin_sr[IN_WIDTH-2:0], 1'b0};
                    ovf_acc <= ovf_acc | bcd_adj[BCD_W-1];
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    bcd_out  <= bcd_sr;
                    overflow <= ovf_acc;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed and random checks of bin_to_bcd_seq with a 5-digit and a 4-digit instance sharing stimulus.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] bin_in;

    logic        busy, done, overflow;
    logic [19:0] bcd_out;
    logic        busy4, done4, overflow4;
    logic [15:0] bcd_out4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.IN_WIDTH(16), .NUM_DIGITS(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow)
    );

    bin_to_bcd_seq #(.IN_WIDTH(16), .NUM_DIGITS(4)) dut4 (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy4),
        .done     (done4),
        .bcd_out  (bcd_out4),
        .overflow (overflow4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Decimal reference: low nd digits of v packed as BCD.
    function automatic logic [31:0] bcd_of(input int unsigned v, input int unsigned nd);
        logic [31:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int unsigned i = 0; i < nd; i++) begin
            r = r | (32'(x % 10) << (4 * i));
            x = x / 10;
        end
        return r;
    endfunction

    // Called at a negedge; returns at the negedge where done is seen (or after the bound).
    task automatic conv(input logic [15:0] v, output int lat, output int busy_n);
        start  = 1'b1;
        bin_in = v;
        @(negedge clk);
        start  = 1'b0;
        bin_in = ~v;
        lat    = 0;
        busy_n = 0;
        while (!done && lat < 40) begin
            if (busy) busy_n++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, busy_n, done_n;
        logic [19:0] seen;
        logic [15:0] v;

        reset  = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd", 32'(bcd_out), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_busy4", 32'(busy4), 32'd0);

        // Zero input
        conv(16'd0, lat, busy_n);
        check("zero_lat", 32'(lat), 32'd17);
        check("zero_bcd", 32'(bcd_out), 32'h00000);
        check("zero_ovf", 32'(overflow), 32'd0);

        // Full-scale input, busy width and done width
        conv(16'd65535, lat, busy_n);
        check("max_lat", 32'(lat), 32'd17);
        check("max_busy_cycles", 32'(busy_n), 32'd17);
        check("max_busy_low_at_done", 32'(busy), 32'd0);
        check("max_bcd", 32'(bcd_out), 32'h65535);
        check("max_ovf", 32'(overflow), 32'd0);
        check("max_bcd4", 32'(bcd_out4), 32'h5535);
        check("max_ovf4", 32'(overflow4), 32'd1);
        check("max_done4", 32'(done4), 32'd1);
        @(negedge clk);
        check("max_done_one_cycle", 32'(done), 32'd0);
        check("max_bcd_held", 32'(bcd_out), 32'h65535);

        // Back-to-back: second start issued in the done cycle
        conv(16'd1234, lat, busy_n);
        check("b2b_first_lat", 32'(lat), 32'd17);
        check("b2b_first_bcd", 32'(bcd_out), 32'h01234);
        conv(16'd9, lat, busy_n);
        check("b2b_second_lat", 32'(lat), 32'd17);
        check("b2b_second_bcd", 32'(bcd_out), 32'h00009);

        // Start while busy is ignored; bin_in changes after capture do nothing
        @(negedge clk);
        start  = 1'b1;
        bin_in = 16'd4321;
        @(negedge clk);
        start  = 1'b0;
        bin_in = 16'd7777;
        repeat (4) @(negedge clk);
        start  = 1'b1;
        bin_in = 16'd999;
        @(negedge clk);
        start  = 1'b0;
        bin_in = 16'd1111;
        done_n = 0;
        seen   = '0;
        for (int i = 0; i < 45; i++) begin
            if (done) begin
                done_n++;
                seen = bcd_out;
            end
            @(negedge clk);
        end
        check("ignore_done_count", 32'(done_n), 32'd1);
        check("ignore_bcd", 32'(seen), 32'h04321);

        // Reset mid-conversion aborts it
        start  = 1'b1;
        bin_in = 16'd500;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_bcd", 32'(bcd_out), 32'd0);
        done_n = 0;
        for (int i = 0; i < 25; i++) begin
            if (done) done_n++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(done_n), 32'd0);
        conv(16'd42, lat, busy_n);
        check("after_abort_lat", 32'(lat), 32'd17);
        check("after_abort_bcd", 32'(bcd_out), 32'h00042);

        // Four-digit boundary cases
        conv(16'd9999, lat, busy_n);
        check("d4_9999_bcd", 32'(bcd_out4), 32'h9999);
        check("d4_9999_ovf", 32'(overflow4), 32'd0);
        conv(16'd12345, lat, busy_n);
        check("d4_12345_bcd", 32'(bcd_out4), 32'h2345);
        check("d4_12345_ovf", 32'(overflow4), 32'd1);
        check("d5_12345_bcd", 32'(bcd_out), 32'h12345);
        conv(16'd10000, lat, busy_n);
        check("d4_10000_bcd", 32'(bcd_out4), 32'h0000);
        check("d4_10000_ovf", 32'(overflow4), 32'd1);

        // Random values against the decimal model
        for (int i = 0; i < 1000; i++) begin
            v = 16'($urandom_range(0, 65535));
            conv(v, lat, busy_n);
            check("rand_lat", 32'(lat), 32'd17);
            check("rand_bcd", 32'(bcd_out), bcd_of(32'(v), 5));
            check("rand_ovf", 32'(overflow), 32'd0);
            check("rand_bcd4", 32'(bcd_out4), bcd_of(32'(v), 4));
            check("rand_ovf4", 32'(overflow4), (v > 16'd9999) ? 32'd1 : 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
